// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int IDX_ID       = 0;
   localparam int IDX_XFER_CNT = 1;
   localparam int FIRST_RW_IDX = 2;

   localparam logic [31:0] DEF_ID_VALUE = 32'hA9B0_0001;

endpackage

// File: rtl/apb_regfile_slave_regbank.sv
// Register bank behind the APB completer: ID, transfer counter and R/W scratch
// registers, with a combinational read port and the access decode error.
module apb_regbank
   import apb_slave_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = DEF_ID_VALUE
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] addr_i,
   input  logic        write_i,
   input  logic        we_i,
   input  logic        inc_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic [29:0] idx;
   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] xfer_cnt_q;

   assign idx   = addr_i[31:2];
   assign err_o = (addr_i[1:0] != 2'b00)
                  || (idx >= 30'(NUM_REGS))
                  || (write_i && (idx < 30'(FIRST_RW_IDX)));

   always_comb begin
      rdata_o = '0;
      if (!err_o) begin
         if (idx == 30'(IDX_ID)) begin
            rdata_o = ID_VALUE;
         end else if (idx == 30'(IDX_XFER_CNT)) begin
            rdata_o = xfer_cnt_q;
         end else begin
            for (int i = FIRST_RW_IDX; i < NUM_REGS; i++) begin
               if (idx == 30'(i)) rdata_o = regs_q[i];
            end
         end
      end
   end

   // Only scratch entries are ever written; entries 0 and 1 stay at reset value.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         xfer_cnt_q <= '0;
      end else begin
         if (we_i && !err_o) begin
            for (int i = FIRST_RW_IDX; i < NUM_REGS; i++) begin
               if (idx == 30'(i)) regs_q[i] <= wdata_i;
            end
         end
         if (inc_i && !err_o) xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with a programmable number of wait states in front of a small
// register bank; all APB outputs are registered.
//
// state | meaning
// IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
// WAIT  | access phase, wait counter running down
// RESP  | PREADY high; transfer commits on the following edge
module apb_regfile_slave
   import apb_slave_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = DEF_ID_VALUE
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic        write_q;
   logic [31:0] prdata_q, prdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;

   logic        setup;
   logic        commit;
   logic [31:0] dec_addr;
   logic        dec_write;
   logic [31:0] rdata;
   logic        dec_err;

   assign setup  = (state_q == IDLE) && PSEL && !PENABLE;
   assign commit = (state_q == RESP) && PSEL;

   // With zero wait states RESP follows the setup edge directly, so decode the live bus there.
   assign dec_addr  = (state_q == IDLE) ? PADDR  : addr_q;
   assign dec_write = (state_q == IDLE) ? PWRITE : write_q;

   apb_regbank #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) u_regbank (
      .clk_i   (HCLK),
      .rst_n_i (HRESETn),
      .addr_i  (dec_addr),
      .write_i (dec_write),
      .we_i    (commit && write_q),
      .inc_i   (commit),
      .wdata_i (wdata_q),
      .rdata_o (rdata),
      .err_o   (dec_err)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (PENABLE) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      if (state_d == RESP) begin
         pready_d  = 1'b1;
         pslverr_d = dec_err;
         prdata_d  = dec_err ? 32'd0 : rdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         if (setup) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with 2 wait states and one
// with none, checked against a scoreboard fed by a small register model.
module tb_apb_regfile_slave;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [31:0] paddr   [2];
   logic [31:0] pwdata  [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];

   int checks   = 0;
   int failures = 0;

   exp_t        sb[$];
   logic [31:0] mdl_regs [2][16];
   logic [31:0] mdl_cnt  [2];

   always #5 clk = ~clk;

   apb_regfile_slave #(.WAIT_CYCLES(2)) u_a (
      .HCLK(clk), .HRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   apb_regfile_slave #(.WAIT_CYCLES(0)) u_b (
      .HCLK(clk), .HRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         mdl_cnt[u] = '0;
         for (int i = 0; i < 16; i++) mdl_regs[u][i] = '0;
      end
   endtask

   task automatic apb_xfer(input int u, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
      exp_t        e;
      int          idx;
      int          waits;
      logic        done;
      logic [31:0] rd;
      logic        er;
      idx     = int'(addr[31:2]);
      e.wr    = wr;
      e.waits = (u == 0) ? 2 : 0;
      e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd16) || (wr && idx < 2);
      e.rdata = '0;
      if (!e.err) begin
         if (idx == 0)      e.rdata = 32'hA9B0_0001;
         else if (idx == 1) e.rdata = mdl_cnt[u];
         else               e.rdata = mdl_regs[u][idx];
         if (wr) mdl_regs[u][idx] = wd;
         mdl_cnt[u] = mdl_cnt[u] + 32'd1;
      end
      sb.push_back(e);

      psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = addr; pwdata[u] = wd;
      @(posedge clk); #1;
      penable[u] = 1'b1;
      waits = 0; done = 1'b0; rd = '0; er = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (pready[u] === 1'b1) begin
            done = 1'b1; rd = prdata[u]; er = pslverr[u];
         end else begin
            waits++;
         end
      end
      e = sb.pop_front();
      chk({tag, "_ready"}, 32'(done), 32'd1);
      if (done) begin
         chk({tag, "_waits"}, waits, e.waits);
         chk({tag, "_slverr"}, 32'(er), 32'(e.err));
         if (!e.wr || e.err) chk({tag, "_rdata"}, rd, e.rdata);
      end
      @(posedge clk); #1;
      chk({tag, "_ready_1cyc"}, 32'(pready[u]), 32'd0);
      psel[u] = 1'b0; penable[u] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0; paddr[u] = '0; pwdata[u] = '0;
      end
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready_a", 32'(pready[0]), 32'd0);
      chk("rst_slverr_a", 32'(pslverr[0]), 32'd0);
      chk("rst_rdata_a", prdata[0], 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // zero-wait instance: back-to-back writes then counter readback
      for (int i = 0; i < 8; i++)
         apb_xfer(1, 1'b1, 32'(4 * (i + 2)), 32'hC0DE_0000 + 32'(i), "b_wr");
      apb_xfer(1, 1'b0, 32'h4, '0, "b_cnt");
      apb_xfer(1, 1'b0, 32'h14, '0, "b_rd5");

      apb_xfer(0, 1'b0, 32'h0, '0, "a_id");
      apb_xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, "a_wr8");
      apb_xfer(0, 1'b0, 32'h8, '0, "a_rd8");
      apb_xfer(0, 1'b0, 32'h4, '0, "a_cnt1");
      apb_xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, "a_wr_cnt");
      apb_xfer(0, 1'b1, 32'h0, 32'h1, "a_wr_id");
      apb_xfer(0, 1'b0, 32'h41, '0, "a_unal");
      apb_xfer(0, 1'b0, 32'h40, '0, "a_oor");
      apb_xfer(0, 1'b0, 32'h4, '0, "a_cnt2");
      apb_xfer(0, 1'b1, 32'h3C, 32'h0BAD_F00D, "a_wr15");
      apb_xfer(0, 1'b0, 32'h3C, '0, "a_rd15");

      // abort: PSEL drops during WAIT
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'hC; pwdata[0] = 32'h1234;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(negedge clk);
      chk("abort_wait_ready", 32'(pready[0]), 32'd0);
      @(posedge clk); #1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_ready", 32'(pready[0]), 32'd0);
      end
      apb_xfer(0, 1'b0, 32'hC, '0, "a_rdC");
      apb_xfer(0, 1'b0, 32'h4, '0, "a_cnt3");

      // PENABLE without setup must not start a transfer
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'h77;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("noset_ready", 32'(pready[0]), 32'd0);
      end
      @(posedge clk); #1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      apb_xfer(0, 1'b0, 32'h10, '0, "a_rd10");

      // reset in the middle of a write
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h8; pwdata[0] = 32'h5555;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(pready[0]), 32'd0);
      chk("midrst_slverr", 32'(pslverr[0]), 32'd0);
      chk("midrst_rdata", prdata[0], 32'd0);
      psel[0] = 1'b0; penable[0] = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, 32'h8, '0, "a_rd8_rst");
      apb_xfer(0, 1'b0, 32'h4, '0, "a_cnt_rst");
      apb_xfer(1, 1'b0, 32'h4, '0, "b_cnt_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer that terminates the APB side of the AHB-to-APB bridge. It decodes PADDR into a small word-addressed register bank, and inserts a parameterised number of wait states via PREADY. It flags illegal accesses on PSLVERR and keeps a count of successful transfers. It is the default bench and system target behind the bridge's PSEL.

## Interface
Parameters:
- NUM_REGS, 16, number of 32-bit registers (>= 3); index 0 = ID (RO), 1 = XFER_CNT (RO), 2..NUM_REGS-1 = R/W scratch
- WAIT_CYCLES, 2, wait states inserted per transfer (0..15)
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  slave select from bridge
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid only while PREADY=1
- PREADY  out  1  transfer completes on this cycle
- PSLVERR  out  1  error response, valid only while PREADY=1

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA, and load wait counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Counter decrements each edge while PSEL=1 and PENABLE=1.
  - Go to RESP on the edge where the counter is 1.
- RESP:
  - PREADY=1; commit on this edge; always return to IDLE.
  - A following setup phase is sampled in IDLE on the next edge, so back-to-back transfers are supported.
- Decode: index = latched PADDR[31:2]. Error if any of the following hold:
  - PADDR[1:0] != 0
  - index >= NUM_REGS
  - write to index 0 or 1
- Writes:
  - Without error, register[index] <= latched PWDATA on the RESP edge.
  - With error, no register changes.
- Reads:
  - PRDATA = register[index], or 0 on error.
  - Computed from the state at the cycle before RESP, registered on entry to RESP.
- XFER_CNT: +1 (mod 2^32) on every RESP edge with PSLVERR=0. A read of XFER_CNT returns the pre-increment value.
- Abort: if PSEL falls while in WAIT or RESP, return to IDLE with no commit and no XFER_CNT change.

## Timing
- Reset (async assert, sync release): state IDLE, all registers 0 except ID, XFER_CNT=0, PRDATA=0, PREADY=0, PSLVERR=0.
- All outputs are registered. Outside RESP, PREADY=0, PSLVERR=0 and PRDATA=0.
- Latency: setup edge to PREADY=1 is WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0 gives a 2-cycle APB transfer (zero wait).
  - Total access-phase length = WAIT_CYCLES+1.
- PREADY is high for exactly one cycle per transfer.
- PENABLE=1 seen in IDLE without a preceding setup is ignored; no transfer starts.
- Reset mid-transfer: immediate return to IDLE, no commit, outputs 0.
- The counter does not run in IDLE. Reloading happens only on a setup phase.

## Structure
- Package apb_slave_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - localparams IDX_ID=0, IDX_XFER_CNT=1, FIRST_RW_IDX=2
  - default ID_VALUE
- One sub-module, apb_regbank:
  - Holds the register array and XFER_CNT.
  - Provides a combinational read port and a write-enable port.
  - Produces the decode error flag.
- The top module holds the FSM, wait counter and output registers.

## Test plan
- Reset, then read index 0 (PADDR=0x0) with WAIT_CYCLES=2 -> PREADY low for 2 access cycles, then PRDATA=0xA9B0_0001, PSLVERR=0, high for 1 cycle.
- Write 0xDEAD_BEEF to PADDR=0x8, then read 0x8 back-to-back -> read returns 0xDEAD_BEEF; XFER_CNT read at 0x4 returns 2.
- Write to 0x4, read 0x41 (unaligned), read 0x40 (index 16) -> each gives PSLVERR=1 with PRDATA=0. XFER_CNT is unchanged, and a read of 0x4 returns 0.
- WAIT_CYCLES=0 build: 8 back-to-back writes -> each completes in 2 cycles; final XFER_CNT read = 8.
- Drop PSEL during WAIT of a write of 0x1234 to 0xC -> no PREADY. A subsequent read of 0xC returns 0; XFER_CNT is unchanged.
- Assert HRESETn=0 in WAIT after writing 0x5555 to 0x8 -> outputs go to 0 immediately, 0x8 reads 0 after reset release, XFER_CNT=0.
